// File: rtl/dac_playback_buffer_if.sv
// rtl/dac_playback_buffer_if.sv - parallel MCU bus and DAC sample stream of the playback buffer
interface dac_playback_buffer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  bus_en;
    logic                  bus_wr;
    logic [15:0]           bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic [11:0]           dac_data;
    logic                  dac_valid;

    modport master (
        output bus_en, bus_wr, bus_addr, bus_wdata,
        input  bus_rdata, dac_data, dac_valid
    );

    modport slave (
        input  bus_en, bus_wr, bus_addr, bus_wdata,
        output bus_rdata, dac_data, dac_valid
    );
endinterface

// File: rtl/dac_playback_buffer.sv
// rtl/dac_playback_buffer.sv - ping-pong DAC playback buffer with swap-on-wrap commit
// DAC_LOOP_EN: when defined, an underrunning pass replays the front buffer instead of stopping.
module dac_playback_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int BUF_SIZE   = 1024,
    parameter int DIV        = 50
) (
    input  logic                clk,
    input  logic                rst_n,
    dac_playback_buffer_if.slave bus
);
    localparam int AW = $clog2(BUF_SIZE);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DIV);

    localparam logic [15:0]   A_COMMIT = 16'h4000;
    localparam logic [15:0]   A_STATUS = 16'h4001;
    localparam logic [15:0]   A_CTRL   = 16'h4002;
    localparam logic [15:0]   A_LEN    = 16'h4003;
    localparam logic [11:0]   MIDSCALE = 12'h800;
    localparam logic [LW-1:0] LEN_MAX  = LW'(BUF_SIZE);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    logic [2:0]            en_sync_q;
    logic                  en_prev_q;
    logic                  wr_q;
    logic [15:0]           addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [11:0]           dac_data_q, dac_data_d;
    logic                  dac_valid_q, dac_valid_d;
    state_e                state_q, state_d;
    logic                  front_q, front_d;
    logic                  swap_pending_q, swap_pending_d;
    logic                  underrun_q, underrun_d;
    logic                  wr_err_q, wr_err_d;
    logic                  run_q, run_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         div_cnt_q, div_cnt_d;
    logic [LW-1:0]         len_shadow_q, len_shadow_d;
    logic [LW-1:0]         len_active_q, len_active_d;

    // Both banks in one array; the bank select is the top index bit.
    logic [11:0] mem_q [2*BUF_SIZE];

    logic          en_sync;
    logic          wr_commit;
    logic          is_sample;
    logic          sample_wr;
    logic          tick;
    logic          wrap;
    logic [11:0]   back_sample;
    logic [11:0]   front_sample;
    logic [LW-1:0] len_wr;

    assign en_sync      = en_sync_q[2];
    assign wr_commit    = en_prev_q & ~en_sync & wr_q;
    assign is_sample    = (addr_q[15:AW] == '0);
    assign sample_wr    = wr_commit & is_sample & ~swap_pending_q;
    assign back_sample  = mem_q[{~front_q, addr_q[AW-1:0]}];
    assign front_sample = mem_q[{front_q, rd_ptr_q}];
    assign tick         = (state_q == ST_RUN) && run_q && (div_cnt_q == DIV_LAST);
    assign wrap         = tick && ({1'b0, rd_ptr_q} == (len_active_q - LW'(1)));

    always_comb begin
        if (wdata_q == '0) begin
            len_wr = LW'(1);
        end else if (wdata_q > DATA_WIDTH'(BUF_SIZE)) begin
            len_wr = LEN_MAX;
        end else begin
            len_wr = LW'(wdata_q);
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (en_sync) begin
            rdata_d = '0;
            if (is_sample) begin
                rdata_d = DATA_WIDTH'(back_sample);
            end else begin
                case (addr_q)
                    A_COMMIT: rdata_d = DATA_WIDTH'(swap_pending_q);
                    A_STATUS: rdata_d = DATA_WIDTH'({wr_err_q, underrun_q,
                                                     state_q == ST_RUN, swap_pending_q});
                    A_CTRL:   rdata_d = DATA_WIDTH'(run_q);
                    A_LEN:    rdata_d = DATA_WIDTH'(len_shadow_q);
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rd_ptr_d       = rd_ptr_q;
        div_cnt_d      = div_cnt_q;
        dac_data_d     = dac_data_q;
        dac_valid_d    = 1'b0;
        front_d        = front_q;
        swap_pending_d = swap_pending_q;
        underrun_d     = underrun_q;
        wr_err_d       = wr_err_q;
        run_d          = run_q;
        len_shadow_d   = len_shadow_q;
        len_active_d   = len_active_q;

        case (state_q)
            ST_STOP: begin
                rd_ptr_d   = '0;
                div_cnt_d  = '0;
                dac_data_d = MIDSCALE;
                // The cycle that sees run counts as divider step 0.
                if (run_q) begin
                    state_d   = ST_RUN;
                    div_cnt_d = CW'(1);
                end
            end
            ST_RUN: begin
                if (!run_q) begin
                    state_d    = ST_STOP;
                    rd_ptr_d   = '0;
                    div_cnt_d  = '0;
                    dac_data_d = MIDSCALE;
                end else if (tick) begin
                    div_cnt_d   = '0;
                    dac_data_d  = front_sample;
                    dac_valid_d = 1'b1;
                    if (wrap) begin
                        rd_ptr_d = '0;
                        if (swap_pending_q) begin
                            front_d        = ~front_q;
                            swap_pending_d = 1'b0;
                            len_active_d   = len_shadow_q;
                        end else begin
                            underrun_d = 1'b1;
`ifndef DAC_LOOP_EN
                            state_d = ST_STOP;
                            run_d   = 1'b0;
`endif
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + CW'(1);
                end
            end
            default: state_d = ST_STOP;
        endcase

        // Bus writes land after playback so a COMMIT on a wrap tick defers to the next wrap.
        if (wr_commit) begin
            if (is_sample) begin
                if (swap_pending_q) begin
                    wr_err_d = 1'b1;
                end
            end else begin
                case (addr_q)
                    A_COMMIT: begin
                        if (wdata_q[0]) begin
                            swap_pending_d = 1'b1;
                        end
                    end
                    A_CTRL: begin
                        run_d = wdata_q[0];
                        if (wdata_q[1]) begin
                            underrun_d = 1'b0;
                            wr_err_d   = 1'b0;
                        end
                    end
                    A_LEN:   len_shadow_d = len_wr;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_sync_q      <= '0;
            en_prev_q      <= 1'b0;
            wr_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            dac_data_q     <= MIDSCALE;
            dac_valid_q    <= 1'b0;
            state_q        <= ST_STOP;
            front_q        <= 1'b0;
            swap_pending_q <= 1'b0;
            underrun_q     <= 1'b0;
            wr_err_q       <= 1'b0;
            run_q          <= 1'b0;
            rd_ptr_q       <= '0;
            div_cnt_q      <= '0;
            len_shadow_q   <= LEN_MAX;
            len_active_q   <= LEN_MAX;
        end else begin
            en_sync_q <= {en_sync_q[1:0], bus.bus_en};
            en_prev_q <= en_sync;
            if (en_sync) begin
                wr_q    <= bus.bus_wr;
                addr_q  <= bus.bus_addr;
                wdata_q <= bus.bus_wdata;
            end
            rdata_q        <= rdata_d;
            dac_data_q     <= dac_data_d;
            dac_valid_q    <= dac_valid_d;
            state_q        <= state_d;
            front_q        <= front_d;
            swap_pending_q <= swap_pending_d;
            underrun_q     <= underrun_d;
            wr_err_q       <= wr_err_d;
            run_q          <= run_d;
            rd_ptr_q       <= rd_ptr_d;
            div_cnt_q      <= div_cnt_d;
            len_shadow_q   <= len_shadow_d;
            len_active_q   <= len_active_d;
        end
    end

    // A sample write only happens with no swap pending, so front_q cannot flip in the same cycle.
    always_ff @(posedge clk) begin
        if (sample_wr) begin
            mem_q[{~front_q, addr_q[AW-1:0]}] <= wdata_q[11:0];
        end
    end

    assign bus.bus_rdata = rdata_q;
    assign bus.dac_data  = dac_data_q;
    assign bus.dac_valid = dac_valid_q;
endmodule

// File: tb/tb_dac_playback_buffer.sv
// tb/tb_dac_playback_buffer.sv - scoreboard bench for dac_playback_buffer
module tb_dac_playback_buffer;
    localparam int DW  = 16;
    localparam int BUF = 16;
    localparam int DIV = 16;

    localparam logic [15:0] A_COMMIT = 16'h4000;
    localparam logic [15:0] A_STATUS = 16'h4001;
    localparam logic [15:0] A_CTRL   = 16'h4002;
    localparam logic [15:0] A_LEN    = 16'h4003;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dac_playback_buffer_if #(.DATA_WIDTH(DW)) bif ();

    dac_playback_buffer #(
        .DATA_WIDTH(DW),
        .BUF_SIZE  (BUF),
        .DIV       (DIV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    typedef struct {
        logic [11:0] data;
        bit          dc;
        bit          first;
    } dac_exp_t;

    dac_exp_t exp_dac[$];
    int       exp_rd[$];
    string    exp_rd_name[$];
    dac_exp_t mon_e;

    int   tests    = 0;
    int   fails    = 0;
    int   dac_cnt  = 0;
    int   target   = 0;
    int   cyc      = 0;
    int   last_cyc = 0;
    logic rd_chk   = 1'b0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_run(input int base, input int n, input bit first_run, input bit dc);
        for (int i = 0; i < n; i++) begin
            dac_exp_t e;
            e.data  = 12'(base + i);
            e.dc    = dc;
            e.first = first_run && (i == 0);
            exp_dac.push_back(e);
            target++;
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bif.bus_addr  = a;
        bif.bus_wdata = d;
        bif.bus_wr    = 1'b1;
        bif.bus_en    = 1'b1;
        repeat (8) @(posedge clk);
        #1 bif.bus_en = 1'b0;
        repeat (6) @(posedge clk);
        #1 bif.bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, input int req, input string name);
        exp_rd.push_back(req);
        exp_rd_name.push_back(name);
        bif.bus_addr = a;
        bif.bus_wr   = 1'b0;
        bif.bus_en   = 1'b1;
        repeat (8) @(posedge clk);
        #1 rd_chk = 1'b1;
        @(posedge clk);
        #1 rd_chk = 1'b0;
        bif.bus_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic wait_dac(input string name, input int n);
        int t;
        t = 0;
        while (dac_cnt < n && t < 4000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(name, dac_cnt, n);
    endtask

    // Monitor: pops the scoreboard on every DAC strobe and on every bus read sample point.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bif.dac_valid === 1'b1) begin
                dac_cnt++;
                if (exp_dac.size() == 0) begin
                    check("dac_unexpected_strobe", 1, 0);
                end else begin
                    mon_e = exp_dac.pop_front();
                    if (!mon_e.dc) begin
                        check("dac_data", int'(bif.dac_data), int'(mon_e.data));
                    end
                    if (!mon_e.first) begin
                        check("dac_period", cyc - last_cyc, DIV);
                    end
                end
                last_cyc = cyc;
            end
            if (rd_chk === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    check(exp_rd_name.pop_front(), int'(bif.bus_rdata), exp_rd.pop_front());
                end
            end
        end
    end

    initial begin
        bif.bus_en    = 1'b0;
        bif.bus_wr    = 1'b0;
        bif.bus_addr  = '0;
        bif.bus_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dac_data", int'(bif.dac_data), 'h800);
        check("rst_dac_valid", int'(bif.dac_valid), 0);
        check("rst_rdata", int'(bif.bus_rdata), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        bus_read(A_STATUS, 0, "status_reset");
        bus_read(A_LEN, 16, "len_reset");
        bus_read(16'h1234, 0, "unmapped_read");
        bus_write(A_LEN, 16'h0000);
        bus_read(A_LEN, 1, "len_clamp_zero");
        bus_write(A_LEN, 16'h0405);
        bus_read(A_LEN, 16, "len_clamp_max");

        for (int i = 0; i < 16; i++) bus_write(16'(i), 16'(16'h100 + i));
        bus_read(16'd5, 'h105, "back_sample5");
        bus_write(A_COMMIT, 16'h0001);
        bus_read(A_COMMIT, 1, "commit_pending");
        bus_write(16'd3, 16'h0ABC);
        bus_read(16'd3, 'h103, "dropped_write");
        bus_read(A_STATUS, 'h9, "status_wr_err");
        bus_write(A_CTRL, 16'h0002);
        bus_read(A_STATUS, 'h1, "status_w1c_err");

        // Pass 1 plays the never-written bank, then the commit swaps in 0x100..
        push_run(0, 16, 1'b1, 1'b1);
        push_run('h100, 16, 1'b0, 1'b0);
        bus_write(A_CTRL, 16'h0001);
        wait_dac("reach_pass2", 17);
        bus_read(A_STATUS, 'h2, "status_after_first_wrap");
        push_run('h200, 8, 1'b0, 1'b0);
`ifdef DAC_LOOP_EN
        push_run('h200, 8, 1'b0, 1'b0);
`endif
        for (int i = 0; i < 8; i++) bus_write(16'(i), 16'(16'h200 + i));
        bus_write(A_LEN, 16'h0008);
        bus_write(A_COMMIT, 16'h0001);
        wait_dac("reach_pass3_end", target);
`ifdef DAC_LOOP_EN
        bus_write(A_CTRL, 16'h0000);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("stop_dac_midscale", int'(bif.dac_data), 'h800);
        bus_read(A_CTRL, 0, "run_cleared");
        bus_read(A_STATUS, 'h4, "status_underrun");
        bus_write(A_CTRL, 16'h0002);
        bus_read(A_STATUS, 0, "status_w1c_underrun");

        // COMMIT lands on the wrap tick of the 8th sample of this pass.
        push_run('h200, 8, 1'b1, 1'b0);
`ifdef DAC_LOOP_EN
        push_run('h200, 8, 1'b0, 1'b0);
        push_run('h100, 8, 1'b0, 1'b0);
`endif
        bus_write(A_CTRL, 16'h0001);
        repeat (8 * DIV - 14) @(posedge clk);
        #1;
        bus_write(A_COMMIT, 16'h0001);
`ifdef DAC_LOOP_EN
        bus_read(A_STATUS, 'h7, "status_commit_on_wrap");
`else
        bus_read(A_STATUS, 'h5, "status_commit_on_wrap");
        push_run('h200, 8, 1'b1, 1'b0);
        push_run('h100, 8, 1'b0, 1'b0);
        bus_write(A_CTRL, 16'h0001);
`endif
        wait_dac("deferred_swap", target);
`ifdef DAC_LOOP_EN
        bus_write(A_CTRL, 16'h0000);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("stop2_dac_midscale", int'(bif.dac_data), 'h800);
        bus_read(A_STATUS, 'h4, "status_after_deferred_swap");

        // Asynchronous reset in the middle of a pass.
        push_run('h100, 2, 1'b1, 1'b0);
        bus_write(A_CTRL, 16'h0001);
        wait_dac("pre_reset", target);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("reset_dac_data", int'(bif.dac_data), 'h800);
        check("reset_dac_valid", int'(bif.dac_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus_read(A_STATUS, 0, "status_after_reset");
        bus_read(A_LEN, 16, "len_after_reset");
        repeat (3 * DIV) @(posedge clk);
        #1;
        check("no_strobe_after_reset", dac_cnt, target);
        check("dac_queue_empty", exp_dac.size(), 0);
        check("rd_queue_empty", exp_rd.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
